mem_port_arbiter: RTL and testbench

// - Shares one physical memory port (pmem) between the I-cache (fetch, read-only) and D-cache (MEM-stage loads/stores).
// - Sits between the two L1 caches and main memory / L2.
// - Grants one cache-line transaction at a time; round-robin on ties so neither pipeline side starves.

---
 rtl/mem_arb_types.sv | 19 +
 rtl/mem_port_arbiter_checker.sv | 26 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_types.sv
// Shared types and default widths for the memory-port arbiter.
// The arbiter and its checker both use these.
package mem_arb_types;

    localparam int LINE_WIDTH = 256;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_checker.sv
// Run-time checks on the arbiter interface: illegal D-side request encoding and
// mutually exclusive strobes/responses.
module mem_port_arbiter_checker (
    input logic clk,
    input logic reset_n,
    input logic d_read,
    input logic d_write,
    input logic pmem_read,
    input logic pmem_write,
    input logic i_resp,
    input logic d_resp
);

    // Sample the interface every rising edge outside reset.
    always @(posedge clk) begin
        if (reset_n) begin
            a_d_rw_excl: assert (!(d_read && d_write))
                else $warning("mem_port_arbiter: d_read and d_write both set, served as write");
            a_strobe_excl: assert (!(pmem_read && pmem_write))
                else $error("mem_port_arbiter: pmem_read and pmem_write both set");
            a_resp_excl: assert (!(i_resp && d_resp))
                else $error("mem_port_arbiter: i_resp and d_resp both set");
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the I-cache and the D-cache, one line
// transaction at a time, round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int LINE_WIDTH = mem_arb_types::LINE_WIDTH,
    parameter int ADDR_WIDTH = mem_arb_types::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy
);

    import mem_arb_types::arb_state_t;
    import mem_arb_types::arb_grant_t;
    import mem_arb_types::ARB_IDLE;
    import mem_arb_types::ARB_SERVE_I;
    import mem_arb_types::ARB_SERVE_D;
    import mem_arb_types::GRANT_I;
    import mem_arb_types::GRANT_D;

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    arb_grant_t last_grant_r;
    logic       d_req_s;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       done_s;

    assign d_req_s = d_read | d_write;
    assign busy    = (state_r != ARB_IDLE);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Grant decision in IDLE and completion routing while serving; responses depend only on state and pmem_resp.
    always_comb begin
        state_nxt_s = state_r;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        done_s      = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (i_read && d_req_s) begin
                    // Tie: the side that did not win last time goes now.
                    if (last_grant_r == GRANT_I) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_i_s = 1'b1;
                    end
                end else if (i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
                if (grant_i_s) begin
                    state_nxt_s = ARB_SERVE_I;
                end else if (grant_d_s) begin
                    state_nxt_s = ARB_SERVE_D;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_SERVE_I: begin
                if (pmem_resp) begin
                    i_resp      = 1'b1;
                    done_s      = 1'b1;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_SERVE_I;
                end
            end
            ARB_SERVE_D: begin
                if (pmem_resp) begin
                    d_resp      = 1'b1;
                    done_s      = 1'b1;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_SERVE_D;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, fairness pointer and the registered pmem request held for the whole transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB_IDLE;
            last_grant_r <= GRANT_I;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_addr    <= {ADDR_WIDTH{1'b0}};
            pmem_wdata   <= {LINE_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_i_s) begin
                last_grant_r <= GRANT_I;
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_addr    <= i_addr;
            end else if (grant_d_s) begin
                // A read+write collision on the D side is served as a write.
                last_grant_r <= GRANT_D;
                pmem_read    <= ~d_write;
                pmem_write   <= d_write;
                pmem_addr    <= d_addr;
                pmem_wdata   <= d_wdata;
            end else if (done_s) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;
    bit auto_resp = 1'b0;
    int lat_cnt = 2;
    bit i_done;
    bit d_done;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy)
    );

    mem_port_arbiter_checker chk_u (
        .clk(clk), .reset_n(reset_n), .d_read(d_read), .d_write(d_write),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .i_resp(i_resp), .d_resp(d_resp)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Transaction-level model: at most one outstanding line transaction,
    // chosen from pending requests, ties going to whoever did not win last.
    bit          m_active;
    bit          m_write;
    bit          m_side_d;
    bit          m_last_d;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_write  <= 1'b0;
            m_side_d <= 1'b0;
            m_last_d <= 1'b0;
        end else if (m_active) begin
            if (pmem_resp) m_active <= 1'b0;
        end else begin
            bit want_i;
            bit want_d;
            bit pick_d;
            want_i = i_read;
            want_d = d_read | d_write;
            pick_d = (want_i && want_d) ? !m_last_d : want_d;
            if (want_i || want_d) begin
                m_active <= 1'b1;
                m_side_d <= pick_d;
                m_last_d <= pick_d;
                m_write  <= pick_d && d_write;
                m_addr   <= pick_d ? d_addr : i_addr;
                if (pick_d) m_wdata <= d_wdata;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 256'(busy), 256'(m_active));
            chk("pmem_read", 256'(pmem_read), 256'(m_active && !m_write));
            chk("pmem_write", 256'(pmem_write), 256'(m_active && m_write));
            if (m_active) chk("pmem_addr", 256'(pmem_addr), 256'(m_addr));
            if (m_active && m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("i_resp", 256'(i_resp), 256'(m_active && !m_side_d && pmem_resp));
            chk("d_resp", 256'(d_resp), 256'(m_active && m_side_d && pmem_resp));
            chk("i_rdata", i_rdata, pmem_rdata);
            chk("d_rdata", d_rdata, pmem_rdata);
        end
    end

    // One clock step; also plays the memory: fresh read data every cycle and
    // (when enabled) a one-cycle pmem_resp after a random latency.
    task automatic step();
        i_done = i_resp;
        d_done = d_resp;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (auto_resp && (pmem_read || pmem_write)) begin
            if (lat_cnt == 0) begin
                pmem_resp = 1'b1;
                lat_cnt   = $urandom_range(0, 4);
            end else begin
                lat_cnt--;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        int steps;
        bit prev_strobe;
        bit strobe;
        bit exp_d;
        logic [255:0] a5_line;

        reset_n = 1'b0;
        i_read = 1'b0; i_addr = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 256'h0;
        pmem_rdata = 256'h0; pmem_resp = 1'b0;
        a5_line = {32{8'hA5}};
        cmp_en = 1'b1;
        repeat (3) step();
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_pmem_read", 256'(pmem_read), 256'h0);
        chk("rst_pmem_write", 256'(pmem_write), 256'h0);
        chk("rst_pmem_addr", 256'(pmem_addr), 256'h0);
        chk("rst_pmem_wdata", pmem_wdata, 256'h0);
        reset_n = 1'b1;
        step();

        // I-cache read at 0x100, memory answers five cycles later.
        i_addr = 32'h100; i_read = 1'b1;
        step();
        chk("t1_pmem_read", 256'(pmem_read), 256'h1);
        chk("t1_pmem_addr", 256'(pmem_addr), 256'h100);
        repeat (4) step();
        pmem_resp = 1'b1;
        #1;
        chk("t1_i_resp", 256'(i_resp), 256'h1);
        chk("t1_d_resp", 256'(d_resp), 256'h0);
        step();
        i_read = 1'b0;
        chk("t1_i_resp_pulse", 256'(i_resp), 256'h0);
        chk("t1_strobe_clear", 256'(pmem_read), 256'h0);
        step();

        // D-cache write-back of an A5 pattern.
        d_addr = 32'h200; d_wdata = a5_line; d_write = 1'b1;
        step();
        chk("t2_pmem_write", 256'(pmem_write), 256'h1);
        chk("t2_pmem_wdata", pmem_wdata, a5_line);
        chk("t2_pmem_addr", 256'(pmem_addr), 256'h200);
        repeat (2) step();
        pmem_resp = 1'b1;
        #1;
        chk("t2_d_resp", 256'(d_resp), 256'h1);
        chk("t2_i_resp", 256'(i_resp), 256'h0);
        step();
        d_write = 1'b0;
        step();

        // Read and write together: served as a write.
        d_addr = 32'h300; d_read = 1'b1; d_write = 1'b1;
        step();
        chk("t3_pmem_write", 256'(pmem_write), 256'h1);
        chk("t3_pmem_read", 256'(pmem_read), 256'h0);
        pmem_resp = 1'b1;
        #1;
        chk("t3_d_resp", 256'(d_resp), 256'h1);
        step();
        d_read = 1'b0; d_write = 1'b0;
        step();

        // Stray pmem_resp while idle.
        pmem_resp = 1'b1;
        #1;
        chk("t4_i_resp", 256'(i_resp), 256'h0);
        chk("t4_d_resp", 256'(d_resp), 256'h0);
        chk("t4_busy", 256'(busy), 256'h0);
        step();

        // Reset in the middle of a D write-back.
        d_addr = 32'h400; d_wdata = rand_line(); d_write = 1'b1;
        step();
        chk("t5_busy", 256'(busy), 256'h1);
        #2;
        reset_n = 1'b0;
        d_write = 1'b0;
        #1;
        chk("t5_async_write", 256'(pmem_write), 256'h0);
        chk("t5_async_busy", 256'(busy), 256'h0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        pmem_resp = 1'b1;
        #1;
        chk("t5_late_d_resp", 256'(d_resp), 256'h0);
        step();

        // Both sides held continuously: grants alternate D, I, D, I ...
        i_addr = 32'h1000; d_addr = 32'h2000;
        i_read = 1'b1; d_read = 1'b1;
        auto_resp = 1'b1; lat_cnt = 1;
        grants = 0; steps = 0; prev_strobe = 1'b0;
        while (grants < 6 && steps < 200) begin
            step();
            steps++;
            strobe = pmem_read || pmem_write;
            if (strobe && !prev_strobe) begin
                exp_d = (grants % 2) == 0;
                chk("tie_order", 256'(pmem_addr), exp_d ? 256'h2000 : 256'h1000);
                grants++;
            end
            prev_strobe = strobe;
        end
        chk("tie_grant_count", 256'(grants), 256'd6);
        i_read = 1'b0; d_read = 1'b0;
        steps = 0;
        while (busy && steps < 20) begin
            step();
            steps++;
        end
        chk("drain1_idle", 256'(busy), 256'h0);

        // Randomized traffic, checked by the per-cycle compare.
        for (int n = 0; n < 500; n++) begin
            step();
            if (i_done) begin
                i_read = 1'($urandom_range(0, 1));
                i_addr = $urandom() & 32'hFFFF_FFE0;
            end else if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1'b1;
                i_addr = $urandom() & 32'hFFFF_FFE0;
            end else if (i_read && $urandom_range(0, 40) == 0) begin
                i_read = 1'b0;
            end
            if (d_done || (!(d_read || d_write) && $urandom_range(0, 3) == 0)) begin
                bit go;
                bit wr;
                go = d_done ? 1'($urandom_range(0, 1)) : 1'b1;
                wr = 1'($urandom_range(0, 1));
                d_read  = go && !wr;
                d_write = go && wr;
                d_addr  = $urandom() & 32'hFFFF_FFE0;
                d_wdata = rand_line();
            end else if ((d_read || d_write) && $urandom_range(0, 40) == 0) begin
                d_read = 1'b0; d_write = 1'b0;
            end
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        steps = 0;
        while (busy && steps < 20) begin
            step();
            steps++;
        end
        chk("drain2_idle", 256'(busy), 256'h0);
        step();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
